// File: rtl/answer_checker.sv
// Guess checker for the result LEDs: compares NUM_DIGITS entered digits against a
// loadable answer on SUBMIT, counts misses, locks out, and holds each wrong verdict.
module answer_checker #(
    parameter int NUM_DIGITS  = 3,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] ANSWER_DEFAULT = {4'd9, 4'd5, 4'd3}
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]     DIGITS_IN,
    input  logic                              SUBMIT,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]     ANSWER_IN,
    input  logic                              ANSWER_LOAD,
    output logic [1:0]                        RESULT,
    output logic [$clog2(MAX_TRIES+1)-1:0]    TRIES_LEFT,
    output logic                              BUSY
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int AW = NUM_DIGITS * DIGIT_W;

    localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TRIES_ONE  = TW'(1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SHOW   = 3'd2;
    localparam logic [2:0] S_SOLVED = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    localparam logic [1:0] R_NONE    = 2'b00;
    localparam logic [1:0] R_WRONG   = 2'b01;
    localparam logic [1:0] R_CORRECT = 2'b11;
    localparam logic [1:0] R_LOCKED  = 2'b10;

    logic [2:0]            state;
    logic [AW-1:0]         answer_reg;
    logic [AW-1:0]         capture_reg;
    logic [HW-1:0]         hold_cnt;
    logic [TW-1:0]         tries_reg;
    logic [1:0]            result_reg;
    logic [NUM_DIGITS-1:0] digit_match;
    logic                  all_match;

    // Digits above 9 are not special: each digit is a raw DIGIT_W-bit compare.
    always_comb begin
        digit_match = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_match[i] = (capture_reg[i*DIGIT_W +: DIGIT_W] == answer_reg[i*DIGIT_W +: DIGIT_W]);
        end
        all_match = &digit_match;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            answer_reg  <= ANSWER_DEFAULT;
            capture_reg <= '0;
            hold_cnt    <= '0;
            tries_reg   <= TRIES_FULL;
            result_reg  <= R_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ANSWER_LOAD) begin
                        answer_reg <= ANSWER_IN;
                        tries_reg  <= TRIES_FULL;
                        result_reg <= R_NONE;
                    end else if (SUBMIT && (DIGITS_IN != '0)) begin
                        capture_reg <= DIGITS_IN;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (all_match) begin
                        result_reg <= R_CORRECT;
                        state      <= S_SOLVED;
                    end else if (tries_reg > TRIES_ONE) begin
                        result_reg <= R_WRONG;
                        tries_reg  <= tries_reg - TRIES_ONE;
                        hold_cnt   <= '0;
                        state      <= S_SHOW;
                    end else begin
                        result_reg <= R_LOCKED;
                        tries_reg  <= '0;
                        state      <= S_LOCKED;
                    end
                end
                S_SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_SOLVED, S_LOCKED: begin
                    // A reload is the only way out of a finished game short of reset.
                    if (ANSWER_LOAD) begin
                        answer_reg <= ANSWER_IN;
                        tries_reg  <= TRIES_FULL;
                        result_reg <= R_NONE;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign RESULT     = result_reg;
    assign TRIES_LEFT = tries_reg;
    assign BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker: directed scenarios plus a randomized run
// against a transaction-level model of the guessing game.
module tb_answer_checker;

    localparam int ND   = 3;
    localparam int DW   = 4;
    localparam int MT   = 3;
    localparam int HOLD = 4;
    localparam int AW   = ND * DW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] DIGITS_IN = '0;
    logic          SUBMIT = 1'b0;
    logic [AW-1:0] ANSWER_IN = '0;
    logic          ANSWER_LOAD = 1'b0;
    logic [1:0]    RESULT;
    logic [1:0]    TRIES_LEFT;
    logic          BUSY;

    int errors = 0;
    int checks = 0;

    answer_checker #(
        .NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_TRIES(MT), .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK(CLK), .RST(RST), .DIGITS_IN(DIGITS_IN), .SUBMIT(SUBMIT),
        .ANSWER_IN(ANSWER_IN), .ANSWER_LOAD(ANSWER_LOAD),
        .RESULT(RESULT), .TRIES_LEFT(TRIES_LEFT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // digit 0 is the first argument and lands in the LSBs
    function automatic logic [AW-1:0] pack(input int d0, input int d1, input int d2);
        pack = {4'(d2), 4'(d1), 4'(d0)};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic submit(input logic [AW-1:0] d);
        DIGITS_IN = d;
        SUBMIT = 1'b1;
        step();
        SUBMIT = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY === 1'b1 && n < 4 * HOLD + 10) begin
            step();
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_idle: BUSY=%b still after %0d cycles, required 0", BUSY, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b00, 2'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset: RESULT=%b TRIES=%0d BUSY=%b, required 00/3/0", RESULT, TRIES_LEFT, BUSY);
        end
    endtask

    task automatic test_correct();
        do_reset();
        submit(pack(3, 5, 9));
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b11, 2'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL correct: RESULT=%b TRIES=%0d BUSY=%b, required 11/3/1", RESULT, TRIES_LEFT, BUSY);
        end
        submit(pack(1, 1, 1));
        step();
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b11, 2'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL solved_hold: RESULT=%b TRIES=%0d BUSY=%b, required 11/3/1", RESULT, TRIES_LEFT, BUSY);
        end
    endtask

    task automatic lock_out();
        logic [1:0] exp_res;
        for (int i = 0; i < MT; i++) begin
            submit(pack(3, 5, 8));
            exp_res = (i == MT - 1) ? 2'b10 : 2'b01;
            checks++;
            if (RESULT !== exp_res || TRIES_LEFT !== 2'(MT - 1 - i)) begin
                errors++;
                $display("[TB] FAIL lockout_%0d: RESULT=%b TRIES=%0d, required %b/%0d",
                         i, RESULT, TRIES_LEFT, exp_res, MT - 1 - i);
            end
            if (i != MT - 1) wait_idle();
        end
    endtask

    task automatic test_lockout();
        do_reset();
        lock_out();
        submit(pack(3, 5, 9));
        step();
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b10, 2'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL locked_hold: RESULT=%b TRIES=%0d BUSY=%b, required 10/0/1", RESULT, TRIES_LEFT, BUSY);
        end
    endtask

    task automatic test_hold_window();
        int n = 0;
        do_reset();
        DIGITS_IN = pack(3, 5, 8);
        SUBMIT = 1'b1;
        step();
        step();
        // SUBMIT stays high through SHOW; only the first one may count
        while (BUSY === 1'b1 && n < 20) begin
            step();
            n++;
        end
        SUBMIT = 1'b0;
        checks++;
        if (n !== HOLD) begin
            errors++;
            $display("[TB] FAIL hold_len: BUSY fell %0d cycles after CHECK, required %0d", n, HOLD);
        end
        step();
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b01, 2'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hold_submits: RESULT=%b TRIES=%0d BUSY=%b, required 01/2/0", RESULT, TRIES_LEFT, BUSY);
        end
        submit(pack(0, 0, 0));
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b01, 2'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zero_submit: RESULT=%b TRIES=%0d BUSY=%b, required 01/2/0", RESULT, TRIES_LEFT, BUSY);
        end
    endtask

    task automatic test_reload();
        do_reset();
        lock_out();
        ANSWER_IN = pack(2, 7, 4);
        ANSWER_LOAD = 1'b1;
        step();
        ANSWER_LOAD = 1'b0;
        checks++;
        if ({RESULT, TRIES_LEFT, BUSY} !== {2'b00, 2'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reload: RESULT=%b TRIES=%0d BUSY=%b, required 00/3/0", RESULT, TRIES_LEFT, BUSY);
        end
        submit(pack(3, 5, 9));
        checks++;
        if (RESULT !== 2'b01 || TRIES_LEFT !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reload_old: RESULT=%b TRIES=%0d, required 01/2", RESULT, TRIES_LEFT);
        end
        wait_idle();
        submit(pack(2, 7, 4));
        checks++;
        if (RESULT !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reload_new: RESULT=%b, required 11", RESULT);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ANSWER_IN = pack(1, 1, 1);
        DIGITS_IN = pack(1, 1, 1);
        ANSWER_LOAD = 1'b1;
        SUBMIT = 1'b1;
        step();
        ANSWER_LOAD = 1'b0;
        SUBMIT = 1'b0;
        step();
        checks++;
        if ({RESULT, BUSY} !== {2'b00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL priority: RESULT=%b BUSY=%b, required 00/0", RESULT, BUSY);
        end
        submit(pack(1, 1, 1));
        checks++;
        if (RESULT !== 2'b11) begin
            errors++;
            $display("[TB] FAIL priority_load: RESULT=%b, required 11", RESULT);
        end
    endtask

    task automatic test_mid_reset();
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            ANSWER_IN = pack(1, 1, 1);
            ANSWER_LOAD = 1'b1;
            step();
            ANSWER_LOAD = 1'b0;
            DIGITS_IN = pack(3, 5, 9);
            SUBMIT = 1'b1;
            step();
            SUBMIT = 1'b0;
            if (phase == 1) begin
                step();
                step();
            end
            RST = 1'b1;
            step();
            RST = 1'b0;
            checks++;
            if ({RESULT, TRIES_LEFT, BUSY} !== {2'b00, 2'd3, 1'b0}) begin
                errors++;
                $display("[TB] FAIL mid_reset_%0d: RESULT=%b TRIES=%0d BUSY=%b, required 00/3/0",
                         phase, RESULT, TRIES_LEFT, BUSY);
            end
            submit(pack(3, 5, 9));
            checks++;
            if (RESULT !== 2'b11) begin
                errors++;
                $display("[TB] FAIL mid_reset_ans_%0d: RESULT=%b, required 11", phase, RESULT);
            end
        end
    endtask

    // Game-level model: a guess either wins, costs a try, or exhausts the tries.
    task automatic test_random();
        logic [AW-1:0] m_ans;
        logic [AW-1:0] d;
        int            m_tries;
        logic [1:0]    m_result;
        bit            m_over;
        bit            exp_busy;
        int            op;
        do_reset();
        m_ans = pack(3, 5, 9);
        m_tries = MT;
        m_result = 2'b00;
        m_over = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!m_over) wait_idle();
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                d = AW'($urandom);
                ANSWER_IN = d;
                ANSWER_LOAD = 1'b1;
                step();
                ANSWER_LOAD = 1'b0;
                step();
                m_ans = d;
                m_tries = MT;
                m_result = 2'b00;
                m_over = 1'b0;
                exp_busy = 1'b0;
            end else begin
                if (op < 4)       d = m_ans;
                else if (op == 4) d = '0;
                else              d = AW'($urandom);
                submit(d);
                if (m_over || d == '0) begin
                    exp_busy = m_over;
                end else if (d == m_ans) begin
                    m_result = 2'b11;
                    m_over = 1'b1;
                    exp_busy = 1'b1;
                end else if (m_tries > 1) begin
                    m_tries = m_tries - 1;
                    m_result = 2'b01;
                    exp_busy = 1'b1;
                end else begin
                    m_tries = 0;
                    m_result = 2'b10;
                    m_over = 1'b1;
                    exp_busy = 1'b1;
                end
            end
            checks++;
            if (RESULT !== m_result || TRIES_LEFT !== 2'(m_tries) || BUSY !== exp_busy) begin
                errors++;
                $display("[TB] FAIL random_%0d: RESULT=%b TRIES=%0d BUSY=%b, required %b/%0d/%b",
                         k, RESULT, TRIES_LEFT, BUSY, m_result, m_tries, exp_busy);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_correct();
        test_lockout();
        test_hold_window();
        test_reload();
        test_priority();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
